// File: rtl/dfg_fu_arbiter.sv
// rtl/dfg_fu_arbiter.sv - round-robin shared multiply/add unit with fixed-latency result pipeline
//
// Purpose: NREQ DFG nodes share one multiply path (accurate/approximate 16x16)
// and one add path (accurate/approximate 64-bit). One request is granted per
// cycle in round-robin order; its result flows through LAT pipeline stages and
// is presented on res_* with valid/ready backpressure. Issue counters feed the
// energy/error model.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot or zero)
//   req_op                per requester: 0 = multiply, 1 = add
//   req_approx            per requester: 1 = approximate unit
//   req_a/req_b           64-bit operands, requester i at [64i+63:64i]
//   res_valid/res_ready   result handshake
//   res_id/res_data       issuing requester and 64-bit result
//   issue_cnt/approx_cnt  wrapping counts of accepted / approximate requests

// Accurate 16x16 multiplier.
module dfg_mul_acc (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

// Approximate 16x16 multiplier: the four LSBs of each operand are dropped
// before multiplication, removing the low partial-product columns.
module dfg_mul_apx (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [15:0] a_t;
    logic [15:0] b_t;

    assign a_t = a & 16'hFFF0;
    assign b_t = b & 16'hFFF0;
    assign p   = 32'(a_t) * 32'(b_t);
endmodule

// Accurate 64-bit adder, carry-in 0, carry-out discarded.
module dfg_add_acc (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] s
);
    assign s = a + b;
endmodule

// Approximate 64-bit lower-part-OR adder: the low 8 bits are a bitwise OR,
// and the upper 56 bits are an exact sum whose carry-in is a[7] & b[7].
module dfg_add_apx (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] s
);
    logic [55:0] hi;

    assign hi = a[63:8] + b[63:8] + {55'b0, a[7] & b[7]};
    assign s  = {hi, a[7:0] | b[7:0]};
endmodule

module dfg_fu_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ-1:0]      req_approx,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2:0]           res_id,
    output logic [63:0]          res_data,
    output logic [31:0]          issue_cnt,
    output logic [31:0]          approx_cnt
);
    localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [31:0]     issue_cnt_q, issue_cnt_d;
    logic [31:0]     approx_cnt_q, approx_cnt_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [2:0]      id_q   [LAT];
    logic [2:0]      id_d   [LAT];
    logic [63:0]     data_q [LAT];
    logic [63:0]     data_d [LAT];

    logic            stall;
    logic            found;
    logic            fire;
    logic [SELW-1:0] sel;
    logic            op_s;
    logic            approx_s;
    logic [63:0]     a_s;
    logic [63:0]     b_s;
    logic [31:0]     mul0_p, mul1_p;
    logic [63:0]     add0_s, add1_s;
    logic [63:0]     res_new;

    // Requester reached k steps after pointer p, wrapping mod NREQ.
    function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % NREQ;
        return SELW'(s);
    endfunction

    assign stall = vld_q[LAT-1] & ~res_ready;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[rr_idx(ptr_q, k)]) begin
                found = 1'b1;
                sel   = rr_idx(ptr_q, k);
            end
        end
    end

    // The grant is withheld during reset so no transfer can be seen while
    // the pipeline is being cleared.
    assign fire      = found & ~stall & ~rst;
    assign req_ready = fire ? (ONE_HOT0 << sel) : '0;

    // Operand mux feeding all four functional units.
    always_comb begin
        op_s     = 1'b0;
        approx_s = 1'b0;
        a_s      = '0;
        b_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (SELW'(i) == sel) begin
                op_s     = req_op[i];
                approx_s = req_approx[i];
                a_s      = req_a[64*i +: 64];
                b_s      = req_b[64*i +: 64];
            end
        end
    end

    dfg_mul_apx mul_0 (.a(a_s[15:0]), .b(b_s[15:0]), .p(mul0_p));
    dfg_mul_acc mul_1 (.a(a_s[15:0]), .b(b_s[15:0]), .p(mul1_p));
    dfg_add_apx add_0 (.a(a_s), .b(b_s), .s(add0_s));
    dfg_add_acc add_1 (.a(a_s), .b(b_s), .s(add1_s));

    always_comb begin
        if (op_s) begin
            res_new = approx_s ? add0_s : add1_s;
        end else begin
            res_new = {32'b0, approx_s ? mul0_p : mul1_p};
        end
    end

    // Next-state: pipeline shift, pointer and counters all freeze on stall.
    // Data/id of a stage only load when a valid entry arrives, so the output
    // stage keeps its last result while bubbles pass through.
    always_comb begin
        ptr_d        = ptr_q;
        issue_cnt_d  = issue_cnt_q;
        approx_cnt_d = approx_cnt_q;
        vld_d        = vld_q;
        id_d         = id_q;
        data_d       = data_q;
        if (!stall) begin
            vld_d[0] = fire;
            if (fire) begin
                id_d[0]   = 3'(sel);
                data_d[0] = res_new;
            end
            for (int k = 1; k < LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    id_d[k]   = id_q[k-1];
                    data_d[k] = data_q[k-1];
                end
            end
        end
        if (fire) begin
            ptr_d        = sel;
            issue_cnt_d  = issue_cnt_q + 32'd1;
            approx_cnt_d = approx_cnt_q + 32'(approx_s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= SELW'(NREQ - 1);
            issue_cnt_q  <= '0;
            approx_cnt_q <= '0;
            vld_q        <= '0;
            for (int k = 0; k < LAT; k++) begin
                id_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            issue_cnt_q  <= issue_cnt_d;
            approx_cnt_q <= approx_cnt_d;
            vld_q        <= vld_d;
            for (int k = 0; k < LAT; k++) begin
                id_q[k]   <= id_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    assign res_valid  = vld_q[LAT-1];
    assign res_id     = id_q[LAT-1];
    assign res_data   = data_q[LAT-1];
    assign issue_cnt  = issue_cnt_q;
    assign approx_cnt = approx_cnt_q;

endmodule
